// File: rtl/deser_frame_ctrl.sv
// Sequencer for the FIR front-end serial deserializer: frame lock, bit forwarding,
// word capture with ready/valid handshake. Optional macro DESER_FSYNC_CHECK_EN adds sync-error checking.
module deser_frame_ctrl #(
  parameter  int LENGTH = 24,
  localparam int CNT_W  = $clog2(LENGTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_bit_stb,
  input  logic              i_bit,
  input  logic              i_fsync,
  output logic              o_des_en,
  output logic              o_des_din,
  output logic              o_des_din_valid,
  input  logic [LENGTH-1:0] iv_des_dout,
  input  logic              i_des_dout_valid,
  output logic [LENGTH-1:0] ov_sample,
  output logic              o_sample_valid,
  input  logic              i_sample_ready,
  output logic              o_overrun,
`ifdef DESER_FSYNC_CHECK_EN
  output logic [7:0]        ov_sync_err_cnt,
`endif
  output logic              o_busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(LENGTH - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              des_en_q, des_en_d;
  logic              des_din_q, des_din_d;
  logic              des_din_valid_q, des_din_valid_d;
  logic [LENGTH-1:0] sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;
  logic              fwd_s;
  logic              last_s;
`ifdef DESER_FSYNC_CHECK_EN
  logic              sync_err_s;
  logic [7:0]        sync_err_cnt_q, sync_err_cnt_d;
`endif

  // Frame sequencing: state, bit counter and which strobes get forwarded
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    fwd_s     = 1'b0;
    last_s    = 1'b0;
`ifdef DESER_FSYNC_CHECK_EN
    sync_err_s = 1'b0;
`endif
    if (!i_en) begin
      // Dropping enable discards any partial word; a coincident strobe is ignored.
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else if (i_bit_stb) begin
      case (state_q)
        ST_IDLE: begin
          if (i_fsync) begin
            state_d   = ST_SHIFT;
            bit_cnt_d = CNT_W'(1);
            fwd_s     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SHIFT: begin
`ifdef DESER_FSYNC_CHECK_EN
          if (i_fsync && (bit_cnt_q != '0)) begin
            bit_cnt_d  = CNT_W'(1);
            fwd_s      = 1'b1;
            sync_err_s = 1'b1;
          end else if (!i_fsync && (bit_cnt_q == '0)) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            sync_err_s = 1'b1;
          end else if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            fwd_s     = 1'b1;
            last_s    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            fwd_s     = 1'b1;
          end
`else
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            fwd_s     = 1'b1;
            last_s    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            fwd_s     = 1'b1;
          end
`endif
        end
        default: begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Deserializer drive: one-cycle registered copy of each forwarded strobe
  always_comb begin
    des_en_d        = fwd_s;
    des_din_valid_d = fwd_s & last_s;
    if (fwd_s) begin
      des_din_d = i_bit;
    end else begin
      des_din_d = des_din_q;
    end
    busy_d = (state_d == ST_SHIFT);
  end

  // Output word register: a word arriving while the old one is stuck is dropped
  always_comb begin
    sample_d       = sample_q;
    sample_valid_d = sample_valid_q;
    overrun_d      = overrun_q;
    if (i_des_dout_valid) begin
      if (!sample_valid_q || i_sample_ready) begin
        sample_d       = iv_des_dout;
        sample_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (sample_valid_q && i_sample_ready) begin
      sample_valid_d = 1'b0;
    end else begin
      sample_valid_d = sample_valid_q;
    end
  end

`ifdef DESER_FSYNC_CHECK_EN
  // Saturating sync-error counter
  always_comb begin
    if (sync_err_s && (sync_err_cnt_q != 8'hFF)) begin
      sync_err_cnt_d = sync_err_cnt_q + 8'd1;
    end else begin
      sync_err_cnt_d = sync_err_cnt_q;
    end
  end

  // Sync-error counter register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_err_cnt_q <= 8'd0;
    end else begin
      sync_err_cnt_q <= sync_err_cnt_d;
    end
  end

  assign ov_sync_err_cnt = sync_err_cnt_q;
`endif

  // State and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= '0;
      des_en_q        <= 1'b0;
      des_din_q       <= 1'b0;
      des_din_valid_q <= 1'b0;
      sample_q        <= '0;
      sample_valid_q  <= 1'b0;
      overrun_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      des_en_q        <= des_en_d;
      des_din_q       <= des_din_d;
      des_din_valid_q <= des_din_valid_d;
      sample_q        <= sample_d;
      sample_valid_q  <= sample_valid_d;
      overrun_q       <= overrun_d;
      busy_q          <= busy_d;
    end
  end

  assign o_des_en        = des_en_q;
  assign o_des_din       = des_din_q;
  assign o_des_din_valid = des_din_valid_q;
  assign ov_sample       = sample_q;
  assign o_sample_valid  = sample_valid_q;
  assign o_overrun       = overrun_q;
  assign o_busy          = busy_q;

endmodule

// File: doc/deser_frame_ctrl.md
Name: deser_frame_ctrl

Overview:
Sequencer for the FIR front-end serial deserializer.
- Locks to a serial bitstream using a bit strobe and a frame-sync marker.
- Drives the deserializer's enable, data and end-of-word strobe.
- Captures each completed parallel word into a ready/valid output register feeding the filter core.
- Flags overruns, and optionally frame-sync errors.

Parameters:
- LENGTH, 24, word length in bits (>= 2); must match the deserializer instance.
- CNT_W, $clog2(LENGTH), bit-counter width (derived, not overridden).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_en  in  1  block enable; low forces IDLE.
- i_bit_stb  in  1  one-cycle strobe, current serial bit is valid.
- i_bit  in  1  serial data bit, LSB first.
- i_fsync  in  1  qualified by i_bit_stb; marks bit 0 of a word.
- o_des_en  out  1  deserializer enable (one pulse per bit).
- o_des_din  out  1  deserializer serial data.
- o_des_din_valid  out  1  deserializer end-of-word strobe (with last bit).
- iv_des_dout  in  LENGTH  deserializer parallel word.
- i_des_dout_valid  in  1  deserializer word-valid.
- ov_sample  out  LENGTH  captured word to filter.
- o_sample_valid  out  1  ov_sample holds an unconsumed word.
- i_sample_ready  in  1  filter accepts word.
- o_overrun  out  1  sticky: a word was dropped.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (async, i_rst=1): state IDLE, bit_cnt 0, all outputs 0 (o_des_*, ov_sample, o_sample_valid, o_overrun, o_busy).
- States: IDLE, SHIFT.
- IDLE:
  - Ignore strobes without fsync.
  - On i_bit_stb & i_fsync & i_en: go to SHIFT, bit_cnt <= 1, forward the bit.
- SHIFT:
  - On each i_bit_stb: forward the bit, bit_cnt <= bit_cnt+1.
  - On the strobe where bit_cnt == LENGTH-1: also assert o_des_din_valid, bit_cnt <= 0, stay in SHIFT (back-to-back words; the next strobe is bit 0 of the next word).
- Forwarding (registered, 1-cycle latency):
  - Strobe in cycle n gives o_des_en=1 and o_des_din=i_bit in cycle n+1.
  - o_des_din_valid is high only with the last bit's o_des_en.
  - With no strobe, o_des_en=0 and o_des_din_valid=0; o_des_din holds its value.
- i_en low (synchronous): next cycle state IDLE, bit_cnt 0, no forwarding.
  - The partial word is discarded; the deserializer is never given o_des_din_valid for it.
  - ov_sample, o_sample_valid and o_overrun retain their values.
- Capture:
  - i_des_dout_valid with o_sample_valid=0: ov_sample <= iv_des_dout, o_sample_valid <= 1 next cycle.
  - End-to-end latency: last-bit strobe at cycle n gives o_sample_valid at n+3 (deserializer registers at n+2).
- Handshake:
  - Transfer occurs on o_sample_valid & i_sample_ready; o_sample_valid drops next cycle unless a new word is captured.
  - ov_sample is stable while o_sample_valid=1 and i_sample_ready=0.
- Simultaneous events:
  - Transfer and i_des_dout_valid in the same cycle: load the new word, o_sample_valid stays 1, no overrun.
  - i_des_dout_valid with o_sample_valid=1 and i_sample_ready=0: drop the new word, keep the old word, set o_overrun (sticky until reset).
- i_bit_stb in the same cycle as i_en falling: strobe ignored.
- o_busy is registered and equals (state == SHIFT).

Optional Feature:
- Macro: DESER_FSYNC_CHECK_EN.
- Defined:
  - In SHIFT, i_bit_stb & i_fsync with bit_cnt != 0 aborts the current word. That bit is forwarded as bit 0 of a new word, bit_cnt <= 1.
  - In SHIFT, i_bit_stb & !i_fsync with bit_cnt == 0 is a missing sync: that bit is not forwarded, and the state goes to IDLE.
  - Each of these events increments output ov_sync_err_cnt (8 bits, saturating at 255, reset 0).
- Undefined:
  - i_fsync is examined only in IDLE; SHIFT counts blindly.
  - ov_sync_err_cnt port is absent.

Test Plan:
- Lock and single word, LENGTH=24: fsync on first strobe, word 0xA5C3F0 sent LSB first, strobes every 3 cycles, filter ready=1 -> ov_sample=0xA5C3F0, o_sample_valid high 1 cycle, o_overrun=0, 24 o_des_en pulses, one o_des_din_valid.
- Back-to-back words 0x000001 then 0x800000 with ready held 0 -> first word held in ov_sample; second dropped; o_overrun=1; after ready=1, ov_sample still 0x000001.
- Strobes on every cycle with ready toggling so that acceptance coincides with each new word -> all 4 words 0x123456, 0xFEDCBA, 0x0F0F0F, 0xF0F0F0 delivered in order, no overrun.
- i_en dropped after 10 bits, then re-enabled with a fresh fsync and word 0x00FF00 -> ov_sample=0x00FF00 only; no o_des_din_valid for the aborted word.
- Async reset asserted mid-word and mid-handshake (o_sample_valid=1) -> all outputs 0 immediately without a clock edge; recovery on the next fsync.
- DESER_FSYNC_CHECK_EN defined: fsync injected at bit 7, then a full word 0x5A5A5A -> ov_sync_err_cnt=1, ov_sample=0x5A5A5A. Then a word start without fsync -> ov_sync_err_cnt=2, o_busy=0.
